// File: rtl/spr_pkg.sv
// Shared constants, state type and interval helper for the SPR averaging stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spr_pkg;

    localparam logic [2:0] SPR_SHIFT_MIN = 3'd3;
    localparam logic [2:0] SPR_SHIFT_MAX = 3'd6;
    localparam int         SPR_FRAC_BITS = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } spr_avg_state_t;

    // Number of samples in a group for a given shift code (3/4/5/6 -> 2/4/8/16).
    function automatic logic [4:0] spr_interval(input logic [2:0] sb);
        logic [2:0] e;
        e = sb - 3'(SPR_FRAC_BITS);
        return 5'd1 << e;
    endfunction

endpackage

// File: rtl/spr_interval_avg_if.sv
// Sample/average bus between the interval-to-shift stage and the averager.
// Latency: n/a (wiring only).
// Backpressure: none; the averager always accepts samples.
interface spr_interval_avg_if #(
    parameter int DW = 8
);
    logic          i_hs;
    logic          i_vs;
    logic [2:0]    shift_bit;
    logic          i_valid;
    logic [DW+1:0] i_data;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_busy;

    modport master (
        output i_hs, i_vs, shift_bit, i_valid, i_data,
        input  o_valid, o_data, o_busy
    );

    modport slave (
        input  i_hs, i_vs, shift_bit, i_valid, i_data,
        output o_valid, o_data, o_busy
    );
endinterface

// File: rtl/spr_round_sat.sv
// Round-half-up then saturate a group sum to DW bits (built only with SPR_ROUND_EN).
// Latency: combinational.
// Backpressure: none.
`ifdef SPR_ROUND_EN
module spr_round_sat #(
    parameter int DW = 8
) (
    input  logic [DW+5:0] acc,
    input  logic [2:0]    shift,
    output logic [DW-1:0] avg
);
    // One extra bit so adding the half never wraps a full 16-sample group.
    localparam int SW = DW + 7;

    logic [SW-1:0] half;
    logic [SW-1:0] sum;
    logic [SW-1:0] shifted;

    // Add half an LSB of the result, shift down, clamp anything above 2^DW-1.
    always_comb begin
        half    = SW'(1) << (shift - 3'd1);
        sum     = SW'(acc) + half;
        shifted = sum >> shift;
        avg     = (|shifted[SW-1:DW]) ? '1 : shifted[DW-1:0];
    end
endmodule
`endif

// File: rtl/spr_interval_avg.sv
// Averages groups of 2^k weighted subpixel samples; rounding/saturation under SPR_ROUND_EN.
// Latency: o_valid one cycle after the last sample of a group.
// Backpressure: none; a sample is taken every i_valid cycle, HS/VS blanking drops partial groups.
module spr_interval_avg
    import spr_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spr_interval_avg_if.slave  bus
);
    localparam int AW = DW + 6;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_ACC  = ACC;

    logic [0:0]    state_q;
    logic [AW-1:0] acc_q;
    logic [4:0]    cnt_q;
    logic [2:0]    shift_q;
    logic          o_valid_q;
    logic [DW-1:0] o_data_q;

    logic          blank;
    logic          shift_ok;
    logic          start;
    logic          accum;
    logic          done;
    logic [AW-1:0] acc_sum;
    logic [4:0]    cnt_nxt;
    logic [DW-1:0] avg_dat;

    // Decode the sample's role: group start, continuation, or group completion.
    always_comb begin
        blank    = !bus.i_hs || !bus.i_vs;
        shift_ok = (bus.shift_bit >= SPR_SHIFT_MIN) && (bus.shift_bit <= SPR_SHIFT_MAX);
        start    = (state_q == ST_IDLE) && bus.i_valid && !blank && shift_ok;
        accum    = (state_q == ST_ACC) && bus.i_valid && !blank;
        acc_sum  = ((state_q == ST_ACC) ? acc_q : '0) + AW'(bus.i_data);
        cnt_nxt  = ((state_q == ST_ACC) ? cnt_q : 5'd0) + 5'd1;
        // A group is at least two samples, so only a continuation can complete one.
        done     = accum && (cnt_nxt == spr_interval(shift_q));
    end

`ifdef SPR_ROUND_EN
    spr_round_sat #(.DW(DW)) u_round (
        .acc   (acc_sum),
        .shift (shift_q),
        .avg   (avg_dat)
    );
`else
    // Truncating normalise; a full group of max samples still fits in DW bits.
    always_comb avg_dat = DW'(acc_sum >> shift_q);
`endif

    // Group state; blanking wins over a coincident sample and drops any partial group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else if (blank) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            o_valid_q <= 1'b0;
        end else begin
            o_valid_q <= done;
            if (start) begin
                shift_q <= bus.shift_bit;
                acc_q   <= acc_sum;
                cnt_q   <= cnt_nxt;
                state_q <= ST_ACC;
            end else if (done) begin
                o_data_q <= avg_dat;
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= ST_IDLE;
            end else if (accum) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_nxt;
            end
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_busy  = (state_q == ST_ACC);

endmodule
